// File: rtl/ov7670_sccb_config.sv
// rtl/ov7670_sccb_config.sv - OV7670 power-up register sequencer over SCCB; optional NACK detection under `SCCB_ACK_CHECK_EN`
module ov7670_sccb_config #(
  parameter int         QUARTER   = 125,
  parameter logic [7:0] DEV_ID    = 8'h42,
  parameter int         ROM_ABITS = 8,
  parameter int         MS_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ROM_ABITS-1:0] rom_addr,
  input  logic [15:0]          rom_data,
  output logic                 sioc,
  output logic                 siod_oe
`ifdef SCCB_ACK_CHECK_EN
  ,
  input  logic                 siod_in,
  output logic                 ack_err
`endif
);

  localparam int QW = $clog2(QUARTER);
  localparam int DW = $clog2(255 * MS_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_BYTE, S_STOP, S_GAP, S_DELAY, S_NEXT, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [QW-1:0]   qcnt;
  logic [1:0]      step;
  logic [3:0]      bit_idx;
  logic [1:0]      byte_idx;
  logic [15:0]     entry;
  logic            fetch_wait;
  logic [DW-1:0]   dcnt;
  logic [DW-1:0]   delay_target;
  logic            qtick;
  logic            accept;
  logic            nack;
  logic            sioc_d;
  logic            oe_d;
  logic [7:0]      cur_byte;

  assign qtick        = (qcnt == QW'(QUARTER - 1));
  assign accept       = (state == S_IDLE || state == S_DONE) && start;
  assign delay_target = DW'(entry[7:0]) * DW'(MS_CYCLES);
  assign cur_byte     = (byte_idx == 2'd0) ? DEV_ID :
                        (byte_idx == 2'd1) ? entry[15:8] : entry[7:0];

`ifdef SCCB_ACK_CHECK_EN
  assign nack = ack_err;
`else
  assign nack = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next-state and bus levels for the current quarter
  always_comb begin
    state_n = state;
    sioc_d  = 1'b1;
    oe_d    = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) state_n = S_FETCH;
      S_FETCH:        if (fetch_wait) state_n = S_DECODE;
      S_DECODE: begin
        if (entry == 16'hFFFF)        state_n = S_DONE;
        else if (entry[15:8] == 8'hF0) state_n = (entry[7:0] == 8'd0) ? S_NEXT : S_DELAY;
        else                          state_n = S_START;
      end
      S_START: begin
        sioc_d = (step == 2'd0);
        oe_d   = 1'b1;
        if (qtick && step == 2'd1) state_n = S_BYTE;
      end
      S_BYTE: begin
        sioc_d = (step == 2'd1) || (step == 2'd2);
        oe_d   = (bit_idx == 4'd8) ? 1'b0 : ~cur_byte[3'd7 - bit_idx[2:0]];
        if (qtick && step == 2'd3 && bit_idx == 4'd8 && (byte_idx == 2'd2 || nack))
          state_n = S_STOP;
      end
      S_STOP: begin
        sioc_d = (step != 2'd0);
        oe_d   = (step != 2'd2);
        if (qtick && step == 2'd2) state_n = nack ? S_DONE : S_GAP;
      end
      S_GAP:   if (qtick && step == 2'd3) state_n = S_NEXT;
      S_DELAY: if (dcnt == delay_target - DW'(1)) state_n = S_NEXT;
      S_NEXT:  state_n = (rom_addr == '1) ? S_DONE : S_FETCH;
      default: state_n = S_IDLE;
    endcase
  end

  // quarter divider plus quarter/bit/byte position; restarts on every state entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt     <= '0;
      step     <= 2'd0;
      bit_idx  <= 4'd0;
      byte_idx <= 2'd0;
    end else begin
      if (state == S_IDLE || state == S_DONE || state_n != state) begin
        qcnt <= '0;
        step <= 2'd0;
      end else if (qtick) begin
        qcnt <= '0;
        step <= step + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end
      if (state != S_BYTE) begin
        bit_idx  <= 4'd0;
        byte_idx <= 2'd0;
      end else if (qtick && step == 2'd3) begin
        if (bit_idx == 4'd8) begin
          bit_idx  <= 4'd0;
          byte_idx <= byte_idx + 2'd1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
        end
      end
    end
  end

  // table fetch (one ROM latency cycle) and delay-marker wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_wait <= 1'b0;
      entry      <= 16'd0;
      dcnt       <= '0;
    end else begin
      fetch_wait <= (state == S_FETCH) && !fetch_wait;
      if (state == S_FETCH && fetch_wait) entry <= rom_data;
      dcnt <= (state == S_DELAY) ? dcnt + DW'(1) : '0;
    end
  end

  // busy/done handshake and table address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_addr <= '0;
    end else begin
      if (accept) begin
        busy     <= 1'b1;
        done     <= 1'b0;
        rom_addr <= '0;
      end else if (state_n == S_DONE && state != S_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (state == S_NEXT && rom_addr != '1) rom_addr <= rom_addr + ROM_ABITS'(1);
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  // sticky NACK flag sampled at the end of Q1 of each ninth bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ack_err <= 1'b0;
    else if (accept)
      ack_err <= 1'b0;
    else if (state == S_BYTE && bit_idx == 4'd8 && step == 2'd1 && qtick && siod_in)
      ack_err <= 1'b1;
  end
`endif

  // registered bus pins so SIOC/SIOD never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sioc    <= 1'b1;
      siod_oe <= 1'b0;
    end else begin
      sioc    <= sioc_d;
      siod_oe <= oe_d;
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb/tb_ov7670_sccb_config.sv - randomized self-checking bench with SCCB bus decoder and table-walk model
module tb_ov7670_sccb_config;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, sioc, siod_oe;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data = 16'd0;
`ifdef SCCB_ACK_CHECK_EN
  logic        siod_in = 1'b0;
  logic        ack_err;
`endif

  ov7670_sccb_config #(.QUARTER(2), .DEV_ID(8'h42), .ROM_ABITS(4), .MS_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .sioc(sioc), .siod_oe(siod_oe)
`ifdef SCCB_ACK_CHECK_EN
    , .siod_in(siod_in), .ack_err(ack_err)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] rom_tbl [16];
  always @(posedge clk) rom_data <= rom_tbl[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // SCCB bus decoder: START/STOP by SIOD edges while SIOC high, bits on SIOC rising edges
  int          nbits = 0, stops = 0, stop_t = 0, start_t = 0, last_gap = 0, frame_len = 0;
  logic [27:0] shreg = '0;
  logic        prev_sioc = 1'b1, prev_oe = 1'b0, in_frame = 1'b0;
  logic [23:0] got[$];

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0; in_frame = 1'b0; prev_sioc = 1'b1; prev_oe = 1'b0;
    end else begin
      if (sioc && prev_sioc && !prev_oe && siod_oe) begin
        in_frame = 1'b1; nbits = 0; start_t = cyc; last_gap = cyc - stop_t;
      end else if (sioc && prev_sioc && prev_oe && !siod_oe) begin
        stops++; stop_t = cyc; frame_len = cyc - start_t;
        if (in_frame && nbits == 28) got.push_back({shreg[27:20], shreg[18:11], shreg[9:2]});
        in_frame = 1'b0;
      end else if (sioc && !prev_sioc && in_frame) begin
        shreg = {shreg[26:0], ~siod_oe};
        nbits++;
      end
      prev_sioc = sioc;
      prev_oe   = siod_oe;
    end
  end

  // reference: walk the table, list expected writes and where rom_addr must stop
  logic [23:0] exp_q[$];
  int          exp_last;

  task automatic model();
    exp_q.delete();
    exp_last = 15;
    for (int i = 0; i < 16; i++) begin
      if (rom_tbl[i] == 16'hFFFF) begin
        exp_last = i;
        break;
      end
      if (rom_tbl[i][15:8] != 8'hF0) exp_q.push_back({8'h42, rom_tbl[i]});
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic launch();
    model();
    got.delete();
    pulse_start();
  endtask

  task automatic finish_run(input string tag);
    int idle_bad = 0;
    int t = 0;
    while (!done && t < 20000) begin
      @(negedge clk);
      if (!busy && !done) idle_bad++;
      t++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(idle_bad), 32'd0);
    chk({tag, "_nwr"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({tag, "_wr"}, 32'(got[i]), 32'(exp_q[i]));
    chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_last));
  endtask

  task automatic wait_bits(input int nb, input int nw);
    int t = 0;
    while (!(got.size() == nw && nbits >= nb) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_bits", 32'(t < 5000), 32'd1);
  endtask

  task automatic rand_table(input logic allow_end);
    int len;
    len = allow_end ? $urandom_range(1, 16) : 16;
    for (int i = 0; i < 16; i++) begin
      if (allow_end && $urandom_range(0, 4) == 0)
        rom_tbl[i] = {8'hF0, 8'($urandom_range(0, 3))};
      else
        rom_tbl[i] = {8'($urandom_range(0, 8'hEF)), 8'($urandom)};
    end
    if (len < 16) rom_tbl[len] = 16'hFFFF;
  endtask

  int gap_delay, gap_nod, a0;

  initial begin
    for (int i = 0; i < 16; i++) rom_tbl[i] = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_sioc", 32'(sioc), 32'd1);
    chk("rst_oe", 32'(siod_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;

    // single write, bus timing of one frame
    rom_tbl[0] = 16'h1280; rom_tbl[1] = 16'hFFFF;
    launch();
    finish_run("one");
    chk("frame_len", 32'(frame_len), 32'd224);

    // delay marker between two writes vs. the same writes without it
    rom_tbl[0] = 16'h1101; rom_tbl[1] = 16'h3A04; rom_tbl[2] = 16'hFFFF;
    launch();
    finish_run("nodly");
    gap_nod = last_gap;
    chk("gap_min", 32'(gap_nod >= 8), 32'd1);
    rom_tbl[0] = 16'h1101; rom_tbl[1] = 16'hF003; rom_tbl[2] = 16'h3A04; rom_tbl[3] = 16'hFFFF;
    a0 = stops;
    launch();
    finish_run("dly");
    gap_delay = last_gap;
    chk("dly_stops", 32'(stops - a0), 32'd2);
    chk("dly_gap", 32'((gap_delay - gap_nod) >= 30 && (gap_delay - gap_nod) <= 40), 32'd1);

    // no end marker: all 16 entries written, address parks at 15
    rand_table(1'b0);
    launch();
    finish_run("full");

    // reset in the middle of the second byte, then replay from entry 0
    rand_table(1'b1);
    rom_tbl[0] = 16'h5A3C;
    launch();
    wait_bits(12, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sioc", 32'(sioc), 32'd1);
    chk("mid_rst_oe", 32'(siod_oe), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    launch();
    finish_run("replay");

    // start while busy is ignored; start in DONE reruns
    rom_tbl[0] = 16'h0102; rom_tbl[1] = 16'h0304; rom_tbl[2] = 16'h0506; rom_tbl[3] = 16'hFFFF;
    launch();
    wait_bits(5, 1);
    a0 = rom_addr;
    pulse_start();
    chk("busy_start_addr", 32'(rom_addr), 32'(a0));
    chk("busy_start_busy", 32'(busy), 32'd1);
    finish_run("busy_start");
    got.delete();
    pulse_start();
    chk("rerun_done", 32'(done), 32'd0);
    chk("rerun_busy", 32'(busy), 32'd1);
    finish_run("rerun");

    // randomized tables against the model
    for (int k = 0; k < 5; k++) begin
      rand_table(1'b1);
      launch();
      finish_run("rand");
    end

`ifdef SCCB_ACK_CHECK_EN
    rom_tbl[0] = 16'h1280; rom_tbl[1] = 16'h3A04; rom_tbl[2] = 16'hFFFF;
    siod_in = 1'b1;
    a0 = stops;
    got.delete();
    pulse_start();
    for (int t = 0; t < 5000 && !done; t++) @(negedge clk);
    chk("nack_err", 32'(ack_err), 32'd1);
    chk("nack_done", 32'(done), 32'd1);
    chk("nack_stops", 32'(stops - a0), 32'd1);
    chk("nack_nwr", 32'(got.size()), 32'd0);
    chk("nack_addr", 32'(rom_addr), 32'd0);
    siod_in = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov7670_sccb_config.md
Name: ov7670_sccb_config

Overview:
- Power-up register sequencer for the OV7670. Sits beside the capture/address path.
- Walks an external synchronous register table and issues one SCCB 3-phase write (device ID, sub-address, data) per entry.
- Honours delay and end-of-table markers in the table.
- Capture logic treats `done` as "sensor configured".

Parameters:
- QUARTER, 125, clk cycles per quarter SIOC period (50 MHz clk -> 100 kHz SIOC); must be >= 2.
- DEV_ID, 8'h42, SCCB write ID byte sent as phase 1.
- ROM_ABITS, 8, table address width.
- MS_CYCLES, 50000, clk cycles per delay-marker millisecond.

Ports:
- clk  in  1  system clock; all logic posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run the table from entry 0.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  high once the table end is reached; held until the next accepted start.
- rom_addr  out  ROM_ABITS  table address.
- rom_data  in  16  table word, valid 1 clk after rom_addr; [15:8] = register, [7:0] = value.
- sioc  out  1  SCCB clock, push-pull.
- siod_oe  out  1  1 = pull SIOD low; 0 = release (the top level ties siod = siod_oe ? 0 : z).

Behaviour:
- Reset (async) values: sioc=1, siod_oe=0, busy=0, done=0, rom_addr=0, state IDLE, all counters 0. A reset mid-transaction returns the bus to idle immediately; no STOP is generated.
- Quarter tick: a divider counts 0..QUARTER-1 and ticks on the wrap. It runs only outside IDLE/DONE and restarts at 0 on every state entry. Every bus-phase step below lasts exactly one quarter.
- IDLE: start=1 -> rom_addr=0, busy=1, go FETCH. Start is ignored while busy=1.
- FETCH: one wait cycle for ROM latency, then latch rom_data into an entry register and go DECODE.
- DECODE (1 cycle), checked in this order:
  - entry==16'hFFFF -> DONE.
  - entry[15:8]==8'hF0 -> DELAY.
  - otherwise -> START.
- START: 2 quarters.
  - Q0: sioc=1, siod_oe=1.
  - Q1: sioc=0, siod_oe=1.
- BYTE: 3 bytes (DEV_ID, entry[15:8], entry[7:0]), 9 bits each, MSB first.
  - Each bit is 4 quarters: Q0 sioc=0 with data set up; Q1 and Q2 sioc=1; Q3 sioc=0.
  - Data bit 1 -> siod_oe=0; data bit 0 -> siod_oe=1.
  - The 9th bit of each byte is the don't-care/ACK slot: siod_oe=0.
- STOP: 3 quarters.
  - Q0: sioc=0, siod_oe=1.
  - Q1: sioc=1, siod_oe=1.
  - Q2: sioc=1, siod_oe=0.
- GAP: 4 quarters of bus idle (sioc=1, oe=0), then NEXT.
- Full write = 2+108+3+4 = 117 quarters.
- DELAY: wait entry[7:0]*MS_CYCLES clks; bus stays idle. A count of 0 takes 0 wait cycles. Then NEXT.
- NEXT:
  - rom_addr == 2^ROM_ABITS-1 -> DONE (implicit end; no wrap to 0).
  - else rom_addr+1 -> FETCH.
- DONE: busy=0, done=1, bus idle. A new start clears done, sets busy, rom_addr=0, go FETCH.
- Arithmetic: counters are sized for worst case (delay counter >= clog2(255*MS_CYCLES)). No overflow is permitted.
- SDA transitions only while sioc=0, except in START/STOP.

Optional Feature:
SCCB_ACK_CHECK_EN:
- Defined:
  - Adds port `siod_in` (in, 1) and port `ack_err` (out, 1, reset 0, sticky until the next accepted start).
  - `siod_in` is sampled at the end of Q1 of each 9th bit. A sample of 1 (NACK) sets ack_err.
  - On NACK, the byte completes, the remaining bytes are skipped, STOP is issued, then the block goes straight to DONE.
- Undefined: no extra ports; the 9th bit is ignored and sequencing is as above.

Test Plan (QUARTER=2, MS_CYCLES=10, ROM_ABITS=4 unless noted):
- Table {16'h1280, 16'hFFFF}, pulse start -> exactly one SCCB write. Decoded SIOD bytes 0x42, 0x12, 0x80. busy high for the whole run. done=1 after 1 write + GAP + FETCH/DECODE overhead. rom_addr stops at 1.
- Table {16'h1101, 16'hF003, 16'h3A04, 16'hFFFF} -> write to 0x11, then 30 clks of bus idle, then write to 0x3A with value 0x04. done=1. Two STOP conditions observed.
- Table with no FFFF marker (16 valid entries) -> 16 writes, done at rom_addr=15, no wrap to 0.
- Assert rst mid-BYTE of the 2nd byte -> same clk edge: sioc=1, siod_oe=0, busy=0. A later start replays the table from entry 0.
- Pulse start while busy -> no restart and rom_addr is unaffected. A start in DONE -> done drops next cycle and the sequence reruns.
- With SCCB_ACK_CHECK_EN: siod_in=1 during the 1st ACK slot -> ack_err=1, STOP issued after byte 1, done=1, no further table entries are fetched.
